hit_cluster_encoder: RTL

- Sits directly downstream of the binary 01 hit-detection stage in the R3_DCL readout path.
- On START, captures that stage's 272-bit buffer: strip hit map [255:0] and header [271:256].
- Scans the hit map for clusters and emits one {address, next-3-strip} word per cluster over a valid/ready handshake.
- Its BUSY output drives the upstream busy input, which stalls buffer writes while an event is being encoded.

---
 rtl/hit_cluster_pkg.sv | 24 ++
 rtl/hit_priority_encoder.sv | 43 ++++
 rtl/hit_cluster_encoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hit_cluster_pkg.sv
// Shared constants and types for the hit cluster encoder.
// NCH    : strip channels in the hit map
// HDR_W  : header bits stored above the hit map in the event buffer
// MAX_CL : clusters emitted per event before truncation
// ADDR_W : cluster address width, clog2(NCH)
package hit_cluster_pkg;

    localparam int NCH    = 256;
    localparam int HDR_W  = 16;
    localparam int MAX_CL = 16;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = $clog2(MAX_CL) + 1;
    localparam int DATA_W = ADDR_W + 3;

    // Address reported for an event without clusters
    localparam logic [ADDR_W-1:0] EMPTY_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/hit_priority_encoder.sv
// Combinational lowest-set-bit encoder over the NCH-bit hit map.
// Two-level tree: sixteen 16-bit groups each resolve a local index,
// then the lowest non-empty group selects which local index is used.
// Ports:
//   vec_i   : hit map to search
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   found_o : at least one bit of vec_i is set
module hit_priority_encoder
    import hit_cluster_pkg::*;
(
    input  logic [NCH-1:0]    vec_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              found_o
);

    logic [15:0] grp_any_s;
    logic [3:0]  grp_idx_s [16];
    logic [3:0]  grp_sel_s;

    // First level: per-group any-bit flag and local lowest index.
    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        for (int g = 0; g < 16; g++) begin
            grp_any_s[g] = |vec_i[g*16 +: 16];
            grp_idx_s[g] = 4'd0;
            for (int b = 15; b >= 0; b--) begin
                grp_idx_s[g] = vec_i[g*16 + b] ? 4'(b) : grp_idx_s[g];
            end
        end
    end

    // Second level: lowest non-empty group selects the final index
    always_comb begin
        grp_sel_s = 4'd0;
        for (int g = 15; g >= 0; g--) begin
            grp_sel_s = grp_any_s[g] ? 4'(g) : grp_sel_s;
        end
    end

    assign idx_o   = {grp_sel_s, grp_idx_s[grp_sel_s]};
    assign found_o = |grp_any_s;

endmodule

// File: rtl/hit_cluster_encoder.sv
// Hit cluster encoder: captures a strip hit map plus header on START
// (or an empty map on NO_0_1), then emits one {address, next-3-strip}
// word per cluster over a valid/ready handshake, at most MAX_CL words.
// Ports:
//   CLK, RST       : clock (rising edge), asynchronous active-low reset
//   START, NO_0_1  : event pulses; DATA_IN sampled only on these
//   DATA_IN        : {header, hit map}
//   CL_READY       : consumer accepts current word
//   CL_VALID       : CL_DATA / CL_LAST / CL_EMPTY valid
//   CL_DATA        : {addr, hit[i+1], hit[i+2], hit[i+3]}
//   CL_LAST        : final word of the event
//   CL_EMPTY       : event without clusters
//   HDR_OUT        : latched header
//   BUSY           : event being encoded, stalls upstream
//   OVF            : event truncated at MAX_CL clusters
//   START_LOST     : event pulse arrived while busy (ignored)
module hit_cluster_encoder
    import hit_cluster_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   NO_0_1,
    input  logic [NCH+HDR_W-1:0]   DATA_IN,
    input  logic                   CL_READY,
    output logic                   CL_VALID,
    output logic [DATA_W-1:0]      CL_DATA,
    output logic                   CL_LAST,
    output logic                   CL_EMPTY,
    output logic [HDR_W-1:0]       HDR_OUT,
    output logic                   BUSY,
    output logic                   OVF,
    output logic                   START_LOST
);

    state_e              state_q,  state_d;
    logic [NCH-1:0]      hitmap_q, hitmap_d;
    logic [HDR_W-1:0]    hdr_q,    hdr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                last_q,   last_d;
    logic                empty_q,  empty_d;
    logic                ovf_q,    ovf_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic                lost_q,   lost_d;

    logic [ADDR_W-1:0]   idx_s;
    logic                found_s;
    logic [NCH-1:0]      shr_s;
    logic [NCH-1:0]      mask_s;
    logic [NCH-1:0]      rem_s;
    logic                at_cap_s;

    hit_priority_encoder u_prio (
        .vec_i   (hitmap_q),
        .idx_o   (idx_s),
        .found_o (found_s)
    );

    // Strips above the cluster start are read from a zero-filled right
    // shift; the clear mask is shifted left so bits past NCH-1 simply fall
    // off instead of wrapping to bit 0.
    assign shr_s    = hitmap_q >> idx_s;
    assign mask_s   = {{(NCH-4){1'b0}}, 4'hF} << idx_s;
    assign rem_s    = hitmap_q & ~mask_s;
    assign at_cap_s = (count_q == CNT_W'(MAX_CL - 1));

    // Next-state and output-register logic for IDLE / SCAN / OUT
    always_comb begin
        state_d  = state_q;
        hitmap_d = hitmap_q;
        hdr_d    = hdr_q;
        count_d  = count_q;
        data_d   = data_q;
        last_d   = last_q;
        empty_d  = empty_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        lost_d   = (START || NO_0_1) && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (START || NO_0_1) begin
                    // START has priority when both pulses coincide
                    hitmap_d = START ? DATA_IN[NCH-1:0] : {NCH{1'b0}};
                    hdr_d    = DATA_IN[NCH +: HDR_W];
                    count_d  = {CNT_W{1'b0}};
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                state_d = OUT;
                if (!found_s) begin
                    data_d  = {EMPTY_ADDR, 3'b000};
                    empty_d = 1'b1;
                    last_d  = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    data_d  = {idx_s, shr_s[1], shr_s[2], shr_s[3]};
                    empty_d = 1'b0;
                    last_d  = (rem_s == {NCH{1'b0}}) || at_cap_s;
                    ovf_d   = at_cap_s && (rem_s != {NCH{1'b0}});
                    // The map is not read again until the word is accepted,
                    // so the cleared map can be stored right away.
                    hitmap_d = rem_s;
                end
            end
            OUT: begin
                if (CL_READY) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    if (last_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            hitmap_q <= {NCH{1'b0}};
            hdr_q    <= {HDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            last_q   <= 1'b0;
            empty_q  <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hitmap_q <= hitmap_d;
            hdr_q    <= hdr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            last_q   <= last_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            lost_q   <= lost_d;
        end
    end

    assign CL_VALID   = valid_q;
    assign CL_DATA    = data_q;
    assign CL_LAST    = last_q;
    assign CL_EMPTY   = empty_q;
    assign HDR_OUT    = hdr_q;
    assign BUSY       = busy_q;
    assign OVF        = ovf_q;
    assign START_LOST = lost_q;

endmodule
